// File: rtl/ps2_key_event_decoder.sv
// PS/2 Set 2 byte stream -> registered key press/release events over valid/ready.
// Optional typematic-repeat suppression when KEY_REPEAT_FILTER_EN is defined.
module ps2_key_event_decoder #(
   parameter int unsigned IDX_W        = 6,
   parameter int unsigned EMIT_RELEASE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             code_valid,
   input  logic [7:0]       code,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [IDX_W-1:0] ev_index,
   output logic [1:0]       ev_class,
   output logic             ev_upper,
   output logic             ev_release,
   output logic             caps_lock,
   output logic             overflow
);

   localparam int unsigned KEY_W      = 6;
   localparam logic [1:0]  CLS_LETTER = 2'd0;
   localparam logic [1:0]  CLS_DIGIT  = 2'd1;
   localparam logic [1:0]  CLS_CTRL   = 2'd2;
   localparam logic [7:0]  PFX_BRK    = 8'hF0;
   localparam logic [7:0]  PFX_EXT    = 8'hE0;

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   state_t           state_q, state_d;
   logic             seq_done, seq_ext, seq_brk;
   logic             base_hit;
   logic [KEY_W-1:0] base_idx;
   logic [1:0]       base_cls;
   logic             key_hit;
   logic [KEY_W-1:0] key_idx;
   logic [1:0]       key_cls;
   logic             key_upper;
   logic             is_repeat;
   logic             ev_gen;
   logic             lshift, rshift;

   // Non-extended scan code lookup
   always_comb begin
      base_hit = 1'b1;
      base_idx = '0;
      base_cls = CLS_LETTER;
      case (code)
         8'h1C: base_idx = 6'd0;   8'h32: base_idx = 6'd1;   8'h21: base_idx = 6'd2;
         8'h23: base_idx = 6'd3;   8'h24: base_idx = 6'd4;   8'h2B: base_idx = 6'd5;
         8'h34: base_idx = 6'd6;   8'h33: base_idx = 6'd7;   8'h43: base_idx = 6'd8;
         8'h3B: base_idx = 6'd9;   8'h42: base_idx = 6'd10;  8'h4B: base_idx = 6'd11;
         8'h3A: base_idx = 6'd12;  8'h31: base_idx = 6'd13;  8'h44: base_idx = 6'd14;
         8'h4D: base_idx = 6'd15;  8'h15: base_idx = 6'd16;  8'h2D: base_idx = 6'd17;
         8'h1B: base_idx = 6'd18;  8'h2C: base_idx = 6'd19;  8'h3C: base_idx = 6'd20;
         8'h2A: base_idx = 6'd21;  8'h1D: base_idx = 6'd22;  8'h22: base_idx = 6'd23;
         8'h35: base_idx = 6'd24;  8'h1A: base_idx = 6'd25;
         8'h45: begin base_idx = 6'd26; base_cls = CLS_DIGIT; end
         8'h16: begin base_idx = 6'd27; base_cls = CLS_DIGIT; end
         8'h1E: begin base_idx = 6'd28; base_cls = CLS_DIGIT; end
         8'h26: begin base_idx = 6'd29; base_cls = CLS_DIGIT; end
         8'h25: begin base_idx = 6'd30; base_cls = CLS_DIGIT; end
         8'h2E: begin base_idx = 6'd31; base_cls = CLS_DIGIT; end
         8'h36: begin base_idx = 6'd32; base_cls = CLS_DIGIT; end
         8'h3D: begin base_idx = 6'd33; base_cls = CLS_DIGIT; end
         8'h3E: begin base_idx = 6'd34; base_cls = CLS_DIGIT; end
         8'h46: begin base_idx = 6'd35; base_cls = CLS_DIGIT; end
         8'h29: begin base_idx = 6'd36; base_cls = CLS_CTRL;  end
         8'h5A: begin base_idx = 6'd37; base_cls = CLS_CTRL;  end
         8'h66: begin base_idx = 6'd38; base_cls = CLS_CTRL;  end
         default: base_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Prefix tracking; a prefix byte arriving mid-sequence ends the sequence unmapped
   always_comb begin
      state_d  = state_q;
      seq_done = 1'b0;
      seq_ext  = 1'b0;
      seq_brk  = 1'b0;
      if (code_valid) begin
         unique case (state_q)
            IDLE: begin
               if (code == PFX_BRK)      state_d = BRK;
               else if (code == PFX_EXT) state_d = EXT;
               else                      seq_done = 1'b1;
            end
            EXT: begin
               if (code == PFX_BRK) state_d = EXT_BRK;
               else begin
                  seq_done = 1'b1;
                  seq_ext  = 1'b1;
                  state_d  = IDLE;
               end
            end
            BRK: begin
               seq_done = 1'b1;
               seq_brk  = 1'b1;
               state_d  = IDLE;
            end
            EXT_BRK: begin
               seq_done = 1'b1;
               seq_ext  = 1'b1;
               seq_brk  = 1'b1;
               state_d  = IDLE;
            end
         endcase
      end
   end

   always_comb begin
      key_hit   = seq_done && (seq_ext ? (code == 8'h5A) : base_hit);
      key_idx   = seq_ext ? 6'd37 : base_idx;
      key_cls   = seq_ext ? CLS_CTRL : base_cls;
      key_upper = (key_cls == CLS_LETTER) ? ((lshift | rshift) ^ caps_lock) : 1'b0;
      ev_gen    = key_hit && (seq_brk ? (EMIT_RELEASE != 0) : !is_repeat);
   end

`ifdef KEY_REPEAT_FILTER_EN
   logic             held_valid;
   logic [KEY_W-1:0] held_idx;

   assign is_repeat = held_valid && (held_idx == key_idx);

   // Last pressed key; cleared by its own break
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held_valid <= 1'b0;
         held_idx   <= '0;
      end else if (key_hit && !seq_brk) begin
         held_valid <= 1'b1;
         held_idx   <= key_idx;
      end else if (key_hit && seq_brk && is_repeat) begin
         held_valid <= 1'b0;
      end
   end
`else
   assign is_repeat = 1'b0;
`endif

   // Modifier state; extended codes (fake shift) never touch it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         caps_lock <= 1'b0;
      end else if (seq_done && !seq_ext) begin
         if (code == 8'h12) lshift <= !seq_brk;
         if (code == 8'h59) rshift <= !seq_brk;
         if (code == 8'h58 && !seq_brk) caps_lock <= !caps_lock;
      end
   end

   // Event holding register; new events are dropped only when full and not draining
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ev_valid   <= 1'b0;
         ev_index   <= '0;
         ev_class   <= '0;
         ev_upper   <= 1'b0;
         ev_release <= 1'b0;
         overflow   <= 1'b0;
      end else if (ev_gen && (!ev_valid || ev_ready)) begin
         ev_valid   <= 1'b1;
         ev_index   <= IDX_W'(key_idx);
         ev_class   <= key_cls;
         ev_upper   <= key_upper;
         ev_release <= seq_brk;
      end else begin
         if (ev_gen)   overflow <= 1'b1;
         if (ev_ready) ev_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Scoreboard bench for ps2_key_event_decoder: stimulus pushes expected events, monitor pops on handshake.
module tb_ps2_key_event_decoder;

   localparam int unsigned IDX_W    = 6;
   localparam int unsigned EMIT_REL = 0;

   typedef struct packed {
      logic [5:0] idx;
      logic [1:0] cls;
      logic       up;
      logic       rel;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             code_valid;
   logic [7:0]       code;
   logic             ev_valid;
   logic             ev_ready;
   logic [IDX_W-1:0] ev_index;
   logic [1:0]       ev_class;
   logic             ev_upper;
   logic             ev_release;
   logic             caps_lock;
   logic             overflow;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;

   ps2_key_event_decoder #(.IDX_W(IDX_W), .EMIT_RELEASE(EMIT_REL)) dut (
      .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_index(ev_index),
      .ev_class(ev_class), .ev_upper(ev_upper), .ev_release(ev_release),
      .caps_lock(caps_lock), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Monitor: every accepted event must match the head of the expectation queue
   always @(negedge clk) begin
      ev_t got, e;
      if (rst_n && ev_valid && ev_ready) begin
         got = '{idx: ev_index, cls: ev_class, up: ev_upper, rel: ev_release};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got idx=%0d cls=%0d up=%0d rel=%0d, none expected",
                     got.idx, got.cls, got.up, got.rel);
         end else begin
            e = exp_q.pop_front();
            if (got != e) begin
               n_err++;
               $display("FAIL event: got idx=%0d cls=%0d up=%0d rel=%0d, expected idx=%0d cls=%0d up=%0d rel=%0d",
                        got.idx, got.cls, got.up, got.rel, e.idx, e.cls, e.up, e.rel);
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      code       = b;
      code_valid = 1'b1;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int idx, input logic [1:0] cls, input logic up, input logic rel);
      ev_t e;
      e = '{idx: 6'(idx), cls: cls, up: up, rel: rel};
      exp_q.push_back(e);
   endtask

   // Make then break of one key, modifier state unchanged in between
   task automatic press_release(input logic [7:0] b, input int idx, input logic [1:0] cls, input logic up);
      push(idx, cls, up, 1'b0);
      send(b);
      if (EMIT_REL != 0) push(idx, cls, up, 1'b1);
      send(8'hF0);
      send(b);
   endtask

   logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   initial begin
      rst_n      = 1'b0;
      code_valid = 1'b0;
      code       = 8'h00;
      ev_ready   = 1'b1;
      idle(3);
      check("reset_ev_valid", int'(ev_valid), 0);
      check("reset_caps", int'(caps_lock), 0);
      check("reset_overflow", int'(overflow), 0);
      rst_n = 1'b1;
      idle(2);

      // Basic press/break, one-cycle latency
      push(0, 2'd0, 1'b0, 1'b0);
      send(8'h1C);
      check("latency_ev_valid", int'(ev_valid), 1);
      if (EMIT_REL != 0) push(0, 2'd0, 1'b0, 1'b1);
      send(8'hF0);
      send(8'h1C);
      idle(2);

      // Shift held vs released
      send(8'h12);
      press_release(8'h1B, 18, 2'd0, 1'b1);
      send(8'hF0); send(8'h12);
      press_release(8'h1B, 18, 2'd0, 1'b0);

      // Right shift takes effect on the very next byte
      send(8'h59);
      press_release(8'h1A, 25, 2'd0, 1'b1);
      send(8'hF0); send(8'h59);

      // Caps Lock inverts the sense of shift
      send(8'h58);
      check("caps_on", int'(caps_lock), 1);
      send(8'h12);
      press_release(8'h1B, 18, 2'd0, 1'b0);
      send(8'hF0); send(8'h12);
      press_release(8'h1B, 18, 2'd0, 1'b1);
      send(8'h58);
      send(8'hF0); send(8'h58);
      check("caps_off_break_ignored", int'(caps_lock), 0);

      // Extended Enter, main Enter, fake shift ignored
      push(37, 2'd2, 1'b0, 1'b0);
      send(8'hE0); send(8'h5A);
      if (EMIT_REL != 0) push(37, 2'd2, 1'b0, 1'b1);
      send(8'hE0); send(8'hF0); send(8'h5A);
      press_release(8'h5A, 37, 2'd2, 1'b0);
      send(8'hE0); send(8'h12);
      press_release(8'h1C, 0, 2'd0, 1'b0);

      // Unmapped and extended-unmapped bytes, and stray prefixes mid-sequence
      send(8'hAA); send(8'hFA); send(8'hEE); send(8'hE1);
      send(8'hE0); send(8'h1C);
      send(8'hF0); send(8'hE0);
      send(8'hE0); send(8'hE0);
      press_release(8'h15, 16, 2'd0, 1'b0);

      // Digits ignore shift; controls
      send(8'h12);
      for (int i = 0; i < 10; i++) press_release(digit_codes[i], 26 + i, 2'd1, 1'b0);
      send(8'hF0); send(8'h12);
      press_release(8'h29, 36, 2'd2, 1'b0);
      press_release(8'h66, 38, 2'd2, 1'b0);
      idle(3);
      check("no_overflow_yet", int'(overflow), 0);

      // Backpressure: second event dropped, then accept and load in one cycle
      ev_ready = 1'b0;
      push(26, 2'd1, 1'b0, 1'b0);
      send(8'h45);
      send(8'h16);
      check("held_valid", int'(ev_valid), 1);
      check("held_index", int'(ev_index), 26);
      check("overflow_set", int'(overflow), 1);
      push(36, 2'd2, 1'b0, 1'b0);
      ev_ready = 1'b1;
      send(8'h29);
      check("reload_valid", int'(ev_valid), 1);
      check("reload_index", int'(ev_index), 36);
      idle(3);
      check("overflow_sticky", int'(overflow), 1);

      // Typematic repeats
      push(0, 2'd0, 1'b0, 1'b0);
`ifndef KEY_REPEAT_FILTER_EN
      push(0, 2'd0, 1'b0, 1'b0);
      push(0, 2'd0, 1'b0, 1'b0);
`endif
      send(8'h1C); send(8'h1C); send(8'h1C);
      if (EMIT_REL != 0) push(0, 2'd0, 1'b0, 1'b1);
      send(8'hF0); send(8'h1C);
      push(0, 2'd0, 1'b0, 1'b0);
`ifndef KEY_REPEAT_FILTER_EN
      push(0, 2'd0, 1'b0, 1'b0);
`endif
      send(8'h1C); send(8'h1C);
      if (EMIT_REL != 0) push(0, 2'd0, 1'b0, 1'b1);
      send(8'hF0); send(8'h1C);
      idle(3);

      // Reset mid-sequence discards partial state and held event
      send(8'h58);
      ev_ready = 1'b0;
      send(8'h32);
      send(8'hF0);
      rst_n = 1'b0;
      idle(1);
      check("rst_ev_valid", int'(ev_valid), 0);
      check("rst_ev_index", int'(ev_index), 0);
      check("rst_ev_class", int'(ev_class), 0);
      check("rst_ev_upper", int'(ev_upper), 0);
      check("rst_ev_release", int'(ev_release), 0);
      check("rst_caps", int'(caps_lock), 0);
      check("rst_overflow", int'(overflow), 0);
      rst_n    = 1'b1;
      ev_ready = 1'b1;
      idle(1);
      push(0, 2'd0, 1'b0, 1'b0);
      send(8'h1C);
      idle(5);

      check("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
